// File: rtl/add_sub_serial_p.sv
// Bit-serial adder/subtractor. Latches two WIDTH-bit operands on a start
// pulse and runs them LSB first through one full-adder cell, one bit per
// clock. It then presents the result, carry-out and signed-overflow flags.
//
// Ports:
//   clk    - clock; all state updates on the rising edge
//   rst    - asynchronous, active-high reset
//   start  - launch request; sampled only when idle or done
//   sub    - 0: a+b, 1: a-b; sampled with start
//   a, b   - WIDTH-bit operands; sampled with start
//   busy   - high while bits are being processed
//   done   - high while result/cout/ovf are valid
//   result - sum/difference modulo 2^WIDTH
//   cout   - final carry; for subtraction 1 means no borrow (a >= b unsigned)
//   ovf    - two's-complement signed overflow
module add_sub_serial_p #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    count_q;
  logic             carry_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic sum_bit;
  logic carry_d;
  logic last_step;

  // Single full-adder cell working on the current LSBs.
  always_comb begin
    sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    carry_d   = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    last_step = (count_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            a_q     <= a;
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            count_q <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= StRun;
          end
        end
        StRun: begin
          carry_q <= carry_d;
          res_q   <= {sum_bit, res_q[WIDTH-1:1]};
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          // Wraps to 0 on the last step when WIDTH is a power of two.
          count_q <= count_q + CW'(1);
          if (last_step) begin
            // Carry into the MSB xor carry out of the MSB.
            ovf_q   <= carry_q ^ carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;
  assign cout   = carry_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_add_sub_serial_p.sv
// Self-checking bench for add_sub_serial_p at WIDTH=8 and WIDTH=16.
// Expected results are queued at launch and compared when done rises.
module tb_add_sub_serial_p;

  typedef struct {
    logic [63:0] res;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, result8;
  logic        start16, sub16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, result16;

  int errors = 0;
  int checks = 0;

  exp_t q8[$];
  exp_t q16[$];
  logic done8_prev  = 1'b0;
  logic done16_prev = 1'b0;

  add_sub_serial_p #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8), .ovf(ovf8)
  );

  add_sub_serial_p #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(result16), .cout(cout16), .ovf(ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference arithmetic on w-bit operands.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic s, input int w);
    logic [64:0] mask;
    logic [64:0] r;
    logic [63:0] am;
    logic [63:0] bb;
    exp_t e;
    mask  = (65'd1 << w) - 65'd1;
    am    = a & mask[63:0];
    bb    = s ? (~b & mask[63:0]) : (b & mask[63:0]);
    r     = {1'b0, am} + {1'b0, bb} + {64'd0, s};
    e.res = r[63:0] & mask[63:0];
    e.c   = r[w];
    e.v   = (am[w-1] == bb[w-1]) && (e.res[w-1] != am[w-1]);
    return e;
  endfunction

  // Scoreboard consumers: pop on each rising edge of done.
  always @(negedge clk) begin
    if (done8 && !done8_prev) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL sb8_unexpected_done: got res=%h with empty queue, want no done", result8);
      end else begin
        exp_t e;
        e = q8.pop_front();
        if ({result8, cout8, ovf8} !== {e.res[7:0], e.c, e.v}) begin
          errors++;
          $display("FAIL sb8: got res=%h c=%b v=%b, want res=%h c=%b v=%b",
                   result8, cout8, ovf8, e.res[7:0], e.c, e.v);
        end
      end
    end
    done8_prev = done8;
  end

  always @(negedge clk) begin
    if (done16 && !done16_prev) begin
      checks++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL sb16_unexpected_done: got res=%h with empty queue, want no done", result16);
      end else begin
        exp_t e;
        e = q16.pop_front();
        if ({result16, cout16, ovf16} !== {e.res[15:0], e.c, e.v}) begin
          errors++;
          $display("FAIL sb16: got res=%h c=%b v=%b, want res=%h c=%b v=%b",
                   result16, cout16, ovf16, e.res[15:0], e.c, e.v);
        end
      end
    end
    done16_prev = done16;
  end

  // Called at a negedge; returns at the negedge right after the load edge.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic s);
    start8 = 1'b1; a8 = a; b8 = b; sub8 = s;
    q8.push_back(model({56'd0, a}, {56'd0, b}, s, 8));
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic launch16(input logic [15:0] a, input logic [15:0] b, input logic s);
    start16 = 1'b1; a16 = a; b16 = b; sub16 = s;
    q16.push_back(model({48'd0, a}, {48'd0, b}, s, 16));
    @(negedge clk);
    start16 = 1'b0;
  endtask

  // Edges counted from the load edge (which counts as 1); bounded.
  task automatic wait_done8(output int edges, output int busy_cycles);
    edges = 1;
    busy_cycles = 0;
    while (!done8 && edges < 40) begin
      if (busy8) busy_cycles++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic wait_done16(output int edges, output int busy_cycles);
    edges = 1;
    busy_cycles = 0;
    while (!done16 && edges < 60) begin
      if (busy16) busy_cycles++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({busy8, done8, result8, cout8, ovf8} !== 12'd0) begin
      errors++;
      $display("FAIL reset8: got busy=%b done=%b res=%h c=%b v=%b, want all 0",
               busy8, done8, result8, cout8, ovf8);
    end
    checks++;
    if ({busy16, done16, result16, cout16, ovf16} !== 20'd0) begin
      errors++;
      $display("FAIL reset16: got busy=%b done=%b res=%h c=%b v=%b, want all 0",
               busy16, done16, result16, cout16, ovf16);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy8, done8);
    end
  endtask

  task automatic test_add_ovf;
    int e, bc;
    launch8(8'h5A, 8'h3C, 1'b0);
    wait_done8(e, bc);
    checks++;
    if (e !== 9) begin
      errors++; $display("FAIL add_latency: got %0d edges, want 9", e);
    end
    checks++;
    if (bc !== 8) begin
      errors++; $display("FAIL add_busy_cycles: got %0d, want 8", bc);
    end
    checks++;
    if ({result8, cout8, ovf8} !== {8'h96, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add_ovf: got res=%h c=%b v=%b, want 96 0 1", result8, cout8, ovf8);
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b1 || result8 !== 8'h96) begin
      errors++;
      $display("FAIL done_hold: got done=%b res=%h, want 1 96", done8, result8);
    end
  endtask

  task automatic test_sub_borrow;
    int e, bc;
    launch8(8'h10, 8'h20, 1'b1);
    wait_done8(e, bc);
    checks++;
    if ({result8, cout8, ovf8} !== {8'hF0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_borrow: got res=%h c=%b v=%b, want f0 0 0", result8, cout8, ovf8);
    end
    launch8(8'h80, 8'h01, 1'b1);
    wait_done8(e, bc);
    checks++;
    if ({result8, cout8, ovf8} !== {8'h7F, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sub_ovf: got res=%h c=%b v=%b, want 7f 1 1", result8, cout8, ovf8);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int e, bc;
    launch8(8'hFF, 8'h01, 1'b0);
    wait_done8(e, bc);
    checks++;
    if ({result8, cout8, ovf8} !== {8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wrap: got res=%h c=%b v=%b, want 00 1 0", result8, cout8, ovf8);
    end
    // Reload in the DONE cycle.
    launch8(8'h01, 8'h02, 1'b0);
    checks++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_bubble: got busy=%b done=%b, want 1 0", busy8, done8);
    end
    wait_done8(e, bc);
    checks++;
    if (e !== 9 || result8 !== 8'h03) begin
      errors++;
      $display("FAIL b2b_result: got edges=%0d res=%h, want 9 03", e, result8);
    end
    @(negedge clk);
  endtask

  task automatic test_isolation;
    logic busy_ok;
    busy_ok = 1'b1;
    launch8(8'h37, 8'h4B, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (busy8 !== 1'b1 || done8 !== 1'b0) busy_ok = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom);
      sub8 = 1'($urandom); start8 = 1'($urandom);
      @(negedge clk);
    end
    start8 = 1'b0;
    checks++;
    if (!busy_ok || done8 !== 1'b1) begin
      errors++;
      $display("FAIL iso_run: got busy_ok=%b done=%b, want 1 1", busy_ok, done8);
    end
    checks++;
    if (result8 !== 8'hEC) begin
      errors++; $display("FAIL iso_result: got %h, want ec", result8);
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL iso_no_restart: got done=%b busy=%b, want 1 0", done8, busy8);
    end
  endtask

  task automatic test_rst_mid;
    launch8(8'hFF, 8'h00, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    start8 = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, result8, cout8, ovf8} !== 12'd0) begin
      errors++;
      $display("FAIL rst_async: got busy=%b done=%b res=%h c=%b v=%b, want all 0",
               busy8, done8, result8, cout8, ovf8);
    end
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b0) begin
      errors++; $display("FAIL rst_wins: got busy=%b, want 0", busy8);
    end
    start8 = 1'b0;
    rst = 1'b0;
    q8.delete();
    repeat (3) @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle: got busy=%b done=%b, want 0 0", busy8, done8);
    end
  endtask

  task automatic test_w16;
    int e, bc;
    launch16(16'hFFFF, 16'hFFFF, 1'b0);
    wait_done16(e, bc);
    checks++;
    if (e !== 17 || bc !== 16) begin
      errors++; $display("FAIL w16_latency: got edges=%0d busy=%0d, want 17 16", e, bc);
    end
    checks++;
    if ({result16, cout16, ovf16} !== {16'hFFFE, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL w16_add: got res=%h c=%b v=%b, want fffe 1 0", result16, cout16, ovf16);
    end
    launch16(16'h8000, 16'h0001, 1'b1);
    wait_done16(e, bc);
    checks++;
    if ({result16, cout16, ovf16} !== {16'h7FFF, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL w16_sub: got res=%h c=%b v=%b, want 7fff 1 1", result16, cout16, ovf16);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int e, bc;
    for (int i = 0; i < 8; i++) begin
      launch8(8'($urandom), 8'($urandom), 1'($urandom));
      wait_done8(e, bc);
      checks++;
      if (e !== 9) begin
        errors++; $display("FAIL rand8_latency: got %0d edges, want 9", e);
      end
    end
    for (int i = 0; i < 4; i++) begin
      launch16(16'($urandom), 16'($urandom), 1'($urandom));
      wait_done16(e, bc);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_add_ovf();
    test_sub_borrow();
    test_back_to_back();
    test_isolation();
    test_rst_mid();
    test_w16();
    test_random();
    repeat (2) @(negedge clk);
    checks++;
    if (q8.size() != 0 || q16.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d/%0d pending, want 0/0", q8.size(), q16.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
